// File: rtl/slc3_top.sv
// SLC-3: simplified LC-3 processor plus board wrapper.
//   Clk          system clock, every register updates on its rising edge
//   Run          active-low button, leaves HALTED and starts fetching
//   Continue     active-low button, releases PAUSE (press, then release)
//   SW[9:0]      slide switches, readable at address 0xFFFF
//   LED[9:0]     code from the last PAUSE instruction
//   HEX0..HEX3   active-low 7-segment (gfedcba) view of the display register
// Holding both buttons low is an asynchronous reset of everything but the RAM.
module slc3_top #(
  parameter int MEM_DEPTH = 256,
  parameter     MEM_INIT  = ""
) (
  input  logic       Clk,
  input  logic       Run,
  input  logic       Continue,
  input  logic [9:0] SW,
  output logic [9:0] LED,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [4:0] {
    HALTED, FETCH1, FETCH2, FETCH3, FETCH4, DECODE,
    EX_ADD, EX_AND, EX_NOT, EX_BR, EX_JMP, EX_JSR1, EX_JSR2,
    EX_LDR1, EX_LDR2, EX_LDR3, EX_LDR4, EX_STR1, EX_STR2,
    PAUSE1, PAUSE2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [15:0]       sr1_q, sr1_d, sr2_q, sr2_d, disp_q, disp_d;
  logic [2:0]        cc_q, cc_d;
  logic              ben_q, ben_d;
  logic [9:0]        led_q, led_d;
  logic [7:0][15:0]  regs_q, regs_d;

  // Probe-friendly names for the architectural state.
  state_t            State;
  logic [15:0]       PC, IR, MAR, MDR, SR1, SR2, DATAP;
  logic [2:0]        CC;
  logic              BEN;
  logic [3:0][3:0]   hex_4;
  assign State = state_q;
  assign PC    = pc_q;
  assign IR    = ir_q;
  assign MAR   = mar_q;
  assign MDR   = mdr_q;
  assign SR1   = sr1_q;
  assign SR2   = sr2_q;
  assign CC    = cc_q;
  assign BEN   = ben_q;
  assign hex_4 = disp_q;

  logic reset_n;
  assign reset_n = Run | Continue;

  // ---------------- memory ----------------
  logic [15:0] mem [MEM_DEPTH];
  logic [15:0] rdata_q;
  logic        mem_we, wb;
  logic        in_ram;
  assign in_ram = ({16'h0, MAR} < MEM_DEPTH);

  initial for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 16'h0;

  // RAM has no reset so its contents survive a button reset. The read port
  // samples MAR every cycle; the FSM picks the word up one state later.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[MAR[AW-1:0]] <= MDR;
    if (in_ram)                rdata_q <= mem[MAR[AW-1:0]];
    else if (MAR == 16'hFFFF)  rdata_q <= {6'b0, SW};
    else                       rdata_q <= 16'h0;
  end

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                return 3'b001;
  endfunction

  // ---------------- control / datapath ----------------
  always_comb begin
    state_d = state_q;  pc_d  = pc_q;  ir_d  = ir_q;  mar_d = mar_q;
    mdr_d   = mdr_q;    cc_d  = cc_q;  ben_d = ben_q; sr1_d = sr1_q;
    sr2_d   = sr2_q;    regs_d = regs_q; led_d = led_q; disp_d = disp_q;
    DATAP   = 16'h0;    mem_we = 1'b0;   wb = 1'b0;
    case (state_q)
      HALTED: if (!Run && Continue) state_d = FETCH1;
      FETCH1: begin DATAP = PC; mar_d = DATAP; pc_d = PC + 16'd1; state_d = FETCH2; end
      FETCH2: state_d = FETCH3;
      FETCH3: begin mdr_d = rdata_q; state_d = FETCH4; end
      FETCH4: begin DATAP = MDR; ir_d = DATAP; state_d = DECODE; end
      DECODE: begin
        ben_d = (IR[11] & CC[2]) | (IR[10] & CC[1]) | (IR[9] & CC[0]);
        // Latch both operands now so every execute state reads registers.
        sr1_d = regs_q[IR[8:6]];
        sr2_d = IR[5] ? {{11{IR[4]}}, IR[4:0]} : regs_q[IR[2:0]];
        case (IR[15:12])
          4'b0001: state_d = EX_ADD;
          4'b0101: state_d = EX_AND;
          4'b1001: state_d = EX_NOT;
          4'b0000: state_d = EX_BR;
          4'b1100: state_d = EX_JMP;
          4'b0100: state_d = EX_JSR1;
          4'b0110: state_d = EX_LDR1;
          4'b0111: state_d = EX_STR1;
          4'b1101: begin led_d = IR[9:0]; state_d = PAUSE1; end
          default: state_d = FETCH1;
        endcase
      end
      EX_ADD:  begin DATAP = SR1 + SR2; wb = 1'b1; state_d = FETCH1; end
      EX_AND:  begin DATAP = SR1 & SR2; wb = 1'b1; state_d = FETCH1; end
      EX_NOT:  begin DATAP = ~SR1;      wb = 1'b1; state_d = FETCH1; end
      EX_BR: begin
        if (BEN) pc_d = PC + {{7{IR[8]}}, IR[8:0]};
        state_d = FETCH1;
      end
      EX_JMP:  begin DATAP = SR1; pc_d = DATAP; state_d = FETCH1; end
      EX_JSR1: begin DATAP = PC; regs_d[7] = DATAP; state_d = EX_JSR2; end
      EX_JSR2: begin pc_d = PC + {{5{IR[10]}}, IR[10:0]}; state_d = FETCH1; end
      EX_LDR1: begin DATAP = SR1 + {{10{IR[5]}}, IR[5:0]}; mar_d = DATAP; state_d = EX_LDR2; end
      EX_LDR2: state_d = EX_LDR3;
      EX_LDR3: begin mdr_d = rdata_q; state_d = EX_LDR4; end
      EX_LDR4: begin DATAP = MDR; wb = 1'b1; state_d = FETCH1; end
      EX_STR1: begin
        DATAP = SR1 + {{10{IR[5]}}, IR[5:0]};
        mar_d = DATAP;
        mdr_d = regs_q[IR[11:9]];
        state_d = EX_STR2;
      end
      EX_STR2: begin
        mem_we = in_ram;
        if (MAR == 16'hFFFF) disp_d = MDR;
        state_d = FETCH1;
      end
      PAUSE1: if (!Continue) state_d = PAUSE2;
      PAUSE2: if (Continue)  state_d = FETCH1;
      default: state_d = HALTED;
    endcase
    if (wb) begin
      regs_d[IR[11:9]] = DATAP;
      cc_d = cc_of(DATAP);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HALTED;  pc_q  <= '0; ir_q  <= '0; mar_q <= '0; mdr_q <= '0;
      sr1_q   <= '0;      sr2_q <= '0; disp_q <= '0; cc_q <= 3'b010; ben_q <= 1'b0;
      led_q   <= '0;      regs_q <= '0;
    end else begin
      state_q <= state_d; pc_q  <= pc_d;  ir_q  <= ir_d;  mar_q <= mar_d; mdr_q <= mdr_d;
      sr1_q   <= sr1_d;   sr2_q <= sr2_d; disp_q <= disp_d; cc_q <= cc_d; ben_q <= ben_d;
      led_q   <= led_d;   regs_q <= regs_d;
    end
  end

  // ---------------- display ----------------
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign LED  = led_q;
  assign HEX0 = seg7(hex_4[0]);
  assign HEX1 = seg7(hex_4[1]);
  assign HEX2 = seg7(hex_4[2]);
  assign HEX3 = seg7(hex_4[3]);
endmodule

// File: tb/tb_slc3_top.sv
module tb_slc3_top;
  logic       Clk = 1'b0, Run = 1'b1, Continue = 1'b1;
  logic [9:0] SW = '0;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  int n_tot = 0, n_bad = 0;

  slc3_top #(.MEM_DEPTH(256)) dut (
    .Clk(Clk), .Run(Run), .Continue(Continue), .SW(SW), .LED(LED),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [15:0] mr [8];
  logic [15:0] mm [256];
  logic [15:0] mpc, mdisp;
  logic [2:0]  mcc;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic signed [15:0] t;
    t = v << (16 - bits);
    return t >>> (16 - bits);
  endfunction

  function automatic logic [2:0] flags(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0)         return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] mload(input logic [15:0] a);
    if (a < 256)       return mm[a[7:0]];
    if (a == 16'hFFFF) return {6'b0, SW};
    return 16'h0;
  endfunction

  // Runs instructions from mpc until a PAUSE; returns its LED code.
  task automatic model_run(output logic [9:0] led);
    logic [15:0] ir, b, ea;
    bit done = 0;
    led = '0;
    for (int s = 0; s < 1000 && !done; s++) begin
      ir = mm[mpc[7:0]];
      mpc = mpc + 1;
      b = ir[5] ? sx(ir, 5) : mr[ir[2:0]];
      ea = mr[ir[8:6]] + sx(ir, 6);
      case (ir[15:12])
        4'h1: begin mr[ir[11:9]] = mr[ir[8:6]] + b; mcc = flags(mr[ir[11:9]]); end
        4'h5: begin mr[ir[11:9]] = mr[ir[8:6]] & b; mcc = flags(mr[ir[11:9]]); end
        4'h9: begin mr[ir[11:9]] = ~mr[ir[8:6]];    mcc = flags(mr[ir[11:9]]); end
        4'h0: if ((ir[11:9] & mcc) != 0) mpc = mpc + sx(ir, 9);
        4'hC: mpc = mr[ir[8:6]];
        4'h4: begin mr[7] = mpc; mpc = mpc + sx(ir, 11); end
        4'h6: begin mr[ir[11:9]] = mload(ea); mcc = flags(mr[ir[11:9]]); end
        4'h7: begin
          if (ea < 256) mm[ea[7:0]] = mr[ir[11:9]];
          else if (ea == 16'hFFFF) mdisp = mr[ir[11:9]];
        end
        4'hD: begin led = ir[9:0]; done = 1; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_br);
    logic [2:0] dr, s1, s2;
    logic [4:0] imm;
    int k;
    dr  = 3'($urandom_range(0, 6)); if (dr == 3'd6) dr = 3'd7;  // R6 is the data base
    s1  = 3'($urandom_range(0, 7));
    s2  = 3'($urandom_range(0, 7));
    imm = 5'($urandom);
    k   = $urandom_range(0, allow_br ? 6 : 5);
    case (k)
      0: return {4'h1, dr, s1, 3'b000, s2};
      1: return {4'h1, dr, s1, 1'b1, imm};
      2: return {4'h5, dr, s1, ($urandom_range(0,1) == 1) ? {1'b1, imm} : {3'b000, s2}};
      3: return {4'h9, dr, s1, 6'h3F};
      4: return {4'h6, dr, 3'd6, 6'($urandom_range(0, 15))};
      5: return {4'h7, s1, 3'd6, 6'($urandom_range(0, 15))};
      default: return {4'h0, 3'($urandom), 9'd1};  // conditional skip of next
    endcase
  endfunction

  // ---------------- bench helpers ----------------
  task automatic do_reset();
    @(negedge Clk); Run = 0; Continue = 0;
    repeat (2) @(negedge Clk);
    Run = 1; Continue = 1;
    @(negedge Clk);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) dut.mem[i] = 16'h0;
  endtask

  task automatic start();
    @(negedge Clk); Run = 0;
    @(negedge Clk); Run = 1;
  endtask

  task automatic wait_led(input logic [9:0] code, input string tag);
    int k = 0;
    while (LED !== code && k < 4000) begin @(negedge Clk); k++; end
    check($sformatf("%s_led", tag), LED, code);
  endtask

  task automatic wait_reg(input int idx, input logic [15:0] v, input string tag);
    int k = 0;
    while (dut.regs_q[idx] !== v && k < 2000) begin @(negedge Clk); k++; end
    check(tag, dut.regs_q[idx], v);
  endtask

  initial begin
    logic [9:0]  code, mcode;
    logic [15:0] maxpc;
    int k;

    // reset state
    do_reset();
    check("rst_pc", dut.PC, 16'h0);
    check("rst_ir", dut.IR, 16'h0);
    check("rst_mar", dut.MAR, 16'h0);
    check("rst_mdr", dut.MDR, 16'h0);
    check("rst_cc", dut.CC, 3'b010);
    check("rst_ben", dut.BEN, 1'b0);
    check("rst_led", LED, 10'h0);
    check("rst_hex", {HEX3, HEX2, HEX1, HEX0}, {4{7'h40}});
    repeat (5) @(negedge Clk);
    check("halt_pc", dut.PC, 16'h0);

    // ADD then PAUSE
    clear_ram(); dut.mem[0] = 16'h1021; dut.mem[1] = 16'hD0AA;
    start();
    wait_led(10'h0AA, "pause");
    check("add_r0", dut.regs_q[0], 16'h1);
    check("add_cc", dut.CC, 3'b001);
    check("pause_pc", dut.PC, 16'h2);
    repeat (10) @(negedge Clk);
    check("pause_hold", dut.PC, 16'h2);
    Continue = 0; repeat (5) @(negedge Clk);
    check("pause2_hold", dut.PC, 16'h2);
    Continue = 1; repeat (12) @(negedge Clk);
    check("pause_release", dut.PC > 16'h2, 1'b1);
    check("led_kept", LED, 10'h0AA);

    // LDR from switch port
    do_reset(); clear_ram(); SW = 10'h006; dut.mem[0] = 16'h62BF;
    start();
    wait_reg(1, 16'h0006, "ldr_r1");
    check("ldr_mar", dut.MAR, 16'hFFFF);
    check("ldr_cc", dut.CC, 3'b001);

    // STR to display register
    do_reset(); clear_ram();
    dut.mem[0] = 16'h126E; dut.mem[1] = 16'h72BF; dut.mem[2] = 16'hD002;
    start();
    wait_led(10'h002, "str");
    check("str_hex0", HEX0, 7'h06);
    check("str_hex321", {HEX3, HEX2, HEX1}, {3{7'h40}});
    check("str_ram0", dut.mem[0], 16'h126E);
    check("str_ram1", dut.mem[1], 16'h72BF);
    check("str_ram255", dut.mem[255], 16'h0);

    // JSR / JMP
    do_reset(); clear_ram();
    dut.mem[0] = 16'h4803; dut.mem[4] = 16'hC1C0; dut.mem[1] = 16'hD003;
    start();
    wait_led(10'h003, "jsr");
    check("jsr_r7", dut.regs_q[7], 16'h1);
    check("jmp_pc", dut.PC, 16'h2);

    // BRz loop, then asynchronous reset mid-run
    do_reset(); clear_ram(); dut.mem[0] = 16'h5020; dut.mem[1] = 16'h05FE;
    start();
    maxpc = 0;
    repeat (80) begin @(negedge Clk); if (dut.PC > maxpc) maxpc = dut.PC; end
    check("brz_loop", maxpc, 16'h2);
    check("brz_cc", dut.CC, 3'b010);
    k = 0;
    while (dut.PC !== 16'h2 && k < 50) begin @(negedge Clk); k++; end
    check("pre_rst_pc", dut.PC, 16'h2);
    Run = 0; Continue = 0; #1;
    check("async_rst_pc", dut.PC, 16'h0);
    check("async_rst_cc", dut.CC, 3'b010);
    check("ram_kept0", dut.mem[0], 16'h5020);
    check("ram_kept1", dut.mem[1], 16'h05FE);
    @(negedge Clk); Run = 1; Continue = 1;
    repeat (5) @(negedge Clk);
    check("rst_halted", dut.PC, 16'h0);

    // BRn never taken
    do_reset(); clear_ram(); dut.mem[0] = 16'h5020; dut.mem[1] = 16'h09FE;
    start();
    repeat (60) @(negedge Clk);
    check("brn_falls", dut.PC > 16'h2, 1'b1);

    // randomized programs against the ISA model
    for (int r = 0; r < 12; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mm[i] = 16'h0;
      for (int i = 0; i < 3; i++) mm[i] = 16'h1DAF;   // R6 = 45, data base
      for (int i = 3; i < 23; i++) mm[i] = rand_instr(i < 22);
      code = 10'($urandom_range(1, 1023));
      mm[23] = 16'hD000 | {6'b0, code};
      for (int i = 45; i < 61; i++) mm[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) dut.mem[i] = mm[i];
      SW = 10'($urandom);
      for (int i = 0; i < 8; i++) mr[i] = 16'h0;
      mpc = 0; mcc = 3'b010; mdisp = 0;
      model_run(mcode);
      start();
      wait_led(mcode, $sformatf("rnd%0d", r));
      for (int i = 0; i < 8; i++)
        check($sformatf("rnd%0d_r%0d", r, i), dut.regs_q[i], mr[i]);
      check($sformatf("rnd%0d_cc", r), dut.CC, mcc);
      check($sformatf("rnd%0d_pc", r), dut.PC, mpc);
      for (int a = 45; a < 61; a++)
        check($sformatf("rnd%0d_m%0d", r, a), dut.mem[a], mm[a]);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
